// File: rtl/uart_cmd_pkg.sv
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared constants and state encoding for the UART command parser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

    typedef logic [2:0] state_t;

    localparam state_t C_ST_IDLE      = 3'd0;
    localparam state_t C_ST_FREQ_PAT  = 3'd1;
    localparam state_t C_ST_FREQ_SLOW = 3'd2;
    localparam state_t C_ST_FREQ_FAST = 3'd3;
    localparam state_t C_ST_DATA_PAT  = 3'd4;
    localparam state_t C_ST_DATA_CTRL = 3'd5;

    localparam logic [7:0] C_CMD_FREQ = 8'h0A;
    localparam logic [7:0] C_CMD_DATA = 8'h0B;

    // Control byte: [7:4] channel, [3] reserved, [2] mode, [1:0] action
    localparam int C_CTRL_CH_LSB   = 4;
    localparam int C_CTRL_MODE_BIT = 2;
    localparam int C_CTRL_ACT_LSB  = 0;

    localparam logic [1:0] C_ACTION_START = 2'b01;

    localparam logic [7:0] C_RST_SLOW_PERIOD = 8'h14;
    localparam logic [7:0] C_RST_FAST_PERIOD = 8'h05;

endpackage

`default_nettype wire

// File: rtl/cmd_byte_shifter.sv
// ============================================================================
// Module      : cmd_byte_shifter
// Description : DATA_BIT-wide accumulator; byte idx_i lands at bits [8*idx+7:8*idx].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_byte_shifter #(
    parameter int DATA_BIT = 32,
    parameter int IDX_W    = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                load_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [7:0]          byte_i,
    output logic [DATA_BIT-1:0] pattern_o
);

    localparam int PAT_BYTES = DATA_BIT / 8;

    logic [DATA_BIT-1:0] r_pattern;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pattern <= '0;
        end else if (clr_i) begin
            r_pattern <= '0;
        end else if (load_i) begin
            for (int k = 0; k < PAT_BYTES; k++) begin
                if (idx_i == IDX_W'(k)) begin
                    r_pattern[8*k +: 8] <= byte_i;
                end
            end
        end
    end

    assign pattern_o = r_pattern;

endmodule

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
// ============================================================================
// Module      : uart_cmd_parser
// Description : Decodes UART byte packets into validated frequency / channel-data
//               register updates; optional inter-byte timeout via
//               UART_CMD_PARSER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         DATA_BIT    = 32,
    parameter int         OUTPUT_NUM  = 3,
    parameter logic [7:0] CMD_FREQ    = C_CMD_FREQ,
    parameter logic [7:0] CMD_DATA    = C_CMD_DATA,
    parameter int         TIMEOUT_CLK = 8000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [7:0]          data_i,
    input  logic                rx_done_tick_i,
    output logic [DATA_BIT-1:0] freq_pattern_o,
    output logic [7:0]          slow_period_o,
    output logic [7:0]          fast_period_o,
    output logic                freq_update_tick_o,
    output logic [DATA_BIT-1:0] data_pattern_o,
    output logic [3:0]          channel_o,
    output logic                mode_o,
    output logic [1:0]          action_o,
    output logic                data_update_tick_o,
    output logic                busy_o,
    output logic                err_tick_o
);

    localparam int PAT_BYTES = DATA_BIT / 8;
    localparam int CNT_W     = $clog2(PAT_BYTES) + 1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_byte_cnt;
    logic [7:0]          r_slow_sh;
    logic [DATA_BIT-1:0] w_freq_shadow;
    logic [DATA_BIT-1:0] w_data_shadow;
    logic                w_busy;
    logic                w_last_pat;
    logic                w_clr;
    logic                w_freq_load;
    logic                w_data_load;
    logic                w_timeout;
    logic [3:0]          w_ch;
    logic                w_ch_ok;

    assign w_busy      = (r_state != C_ST_IDLE);
    assign busy_o      = w_busy;
    assign w_last_pat  = (r_byte_cnt == CNT_W'(PAT_BYTES - 1));
    // Shadow patterns restart at every packet start and on timeout abort
    assign w_clr       = (rx_done_tick_i && (r_state == C_ST_IDLE)) || w_timeout;
    assign w_freq_load = rx_done_tick_i && (r_state == C_ST_FREQ_PAT);
    assign w_data_load = rx_done_tick_i && (r_state == C_ST_DATA_PAT);
    assign w_ch        = data_i[C_CTRL_CH_LSB +: 4];
    assign w_ch_ok     = ({1'b0, w_ch} < 5'(OUTPUT_NUM));

    cmd_byte_shifter #(
        .DATA_BIT (DATA_BIT),
        .IDX_W    (CNT_W)
    ) u_freq_shifter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_clr),
        .load_i    (w_freq_load),
        .idx_i     (r_byte_cnt),
        .byte_i    (data_i),
        .pattern_o (w_freq_shadow)
    );

    cmd_byte_shifter #(
        .DATA_BIT (DATA_BIT),
        .IDX_W    (CNT_W)
    ) u_data_shifter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_clr),
        .load_i    (w_data_load),
        .idx_i     (r_byte_cnt),
        .byte_i    (data_i),
        .pattern_o (w_data_shadow)
    );

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLK + 1);

    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_to_cnt <= '0;
        end else if (rx_done_tick_i || !w_busy) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Fires on the edge at which the idle count would reach TIMEOUT_CLK
    assign w_timeout = w_busy && !rx_done_tick_i && (r_to_cnt == TO_W'(TIMEOUT_CLK - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state            <= C_ST_IDLE;
            r_byte_cnt         <= '0;
            r_slow_sh          <= '0;
            freq_pattern_o     <= '0;
            slow_period_o      <= C_RST_SLOW_PERIOD;
            fast_period_o      <= C_RST_FAST_PERIOD;
            freq_update_tick_o <= 1'b0;
            data_pattern_o     <= '0;
            channel_o          <= '0;
            mode_o             <= 1'b0;
            action_o           <= '0;
            data_update_tick_o <= 1'b0;
            err_tick_o         <= 1'b0;
        end else begin
            freq_update_tick_o <= 1'b0;
            data_update_tick_o <= 1'b0;
            err_tick_o         <= 1'b0;
            if (w_timeout) begin
                r_state    <= C_ST_IDLE;
                r_byte_cnt <= '0;
                r_slow_sh  <= '0;
                err_tick_o <= 1'b1;
            end else if (rx_done_tick_i) begin
                case (r_state)
                    C_ST_IDLE: begin
                        r_byte_cnt <= '0;
                        if (data_i == CMD_FREQ) begin
                            r_state <= C_ST_FREQ_PAT;
                        end else if (data_i == CMD_DATA) begin
                            r_state <= C_ST_DATA_PAT;
                        end else begin
                            err_tick_o <= 1'b1;
                        end
                    end
                    C_ST_FREQ_PAT: begin
                        if (w_last_pat) begin
                            r_state    <= C_ST_FREQ_SLOW;
                            r_byte_cnt <= '0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        end
                    end
                    C_ST_FREQ_SLOW: begin
                        r_slow_sh <= data_i;
                        r_state   <= C_ST_FREQ_FAST;
                    end
                    C_ST_FREQ_FAST: begin
                        r_state   <= C_ST_IDLE;
                        r_slow_sh <= '0;
                        if ((r_slow_sh == 8'h00) || (data_i == 8'h00)) begin
                            err_tick_o <= 1'b1;
                        end else begin
                            freq_pattern_o     <= w_freq_shadow;
                            slow_period_o      <= r_slow_sh;
                            fast_period_o      <= data_i;
                            freq_update_tick_o <= 1'b1;
                        end
                    end
                    C_ST_DATA_PAT: begin
                        if (w_last_pat) begin
                            r_state    <= C_ST_DATA_CTRL;
                            r_byte_cnt <= '0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        end
                    end
                    C_ST_DATA_CTRL: begin
                        r_state <= C_ST_IDLE;
                        if (!w_ch_ok) begin
                            err_tick_o <= 1'b1;
                        end else begin
                            data_pattern_o     <= w_data_shadow;
                            channel_o          <= w_ch;
                            mode_o             <= data_i[C_CTRL_MODE_BIT];
                            action_o           <= data_i[C_CTRL_ACT_LSB +: 2];
                            data_update_tick_o <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= C_ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Self-checking bench for uart_cmd_parser with a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    localparam int DATA_BIT    = 32;
    localparam int OUTPUT_NUM  = 3;
    localparam int TIMEOUT_CLK = 8000;
    localparam int PB          = DATA_BIT / 8;

    typedef logic [7:0] bq_t[$];

    typedef struct packed {
        logic [1:0]  kind;   // 0 reject, 1 freq update, 2 data update
        logic [31:0] pat;
        logic [7:0]  slow;
        logic [7:0]  fast;
        logic [3:0]  ch;
        logic        mode;
        logic [1:0]  act;
    } res_t;

    logic                clk;
    logic                rst;
    logic [7:0]          data;
    logic                rx_tick;
    logic [DATA_BIT-1:0] freq_pattern;
    logic [7:0]          slow_period;
    logic [7:0]          fast_period;
    logic                freq_tick;
    logic [DATA_BIT-1:0] data_pattern;
    logic [3:0]          channel;
    logic                mode;
    logic [1:0]          action;
    logic                data_tick;
    logic                busy;
    logic                err_tick;

    int n_cmp = 0;
    int n_mis = 0;
    int n_f = 0;
    int n_d = 0;
    int n_e = 0;
    int n_ovl = 0;
    int m_f, m_d, m_e;

    logic [31:0] e_fpat, e_dpat;
    logic [7:0]  e_slow, e_fast;
    logic [3:0]  e_ch;
    logic        e_mode;
    logic [1:0]  e_act;

    uart_cmd_parser #(
        .DATA_BIT    (DATA_BIT),
        .OUTPUT_NUM  (OUTPUT_NUM),
        .CMD_FREQ    (8'h0A),
        .CMD_DATA    (8'h0B),
        .TIMEOUT_CLK (TIMEOUT_CLK)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .data_i             (data),
        .rx_done_tick_i     (rx_tick),
        .freq_pattern_o     (freq_pattern),
        .slow_period_o      (slow_period),
        .fast_period_o      (fast_period),
        .freq_update_tick_o (freq_tick),
        .data_pattern_o     (data_pattern),
        .channel_o          (channel),
        .mode_o             (mode),
        .action_o           (action),
        .data_update_tick_o (data_tick),
        .busy_o             (busy),
        .err_tick_o         (err_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Values read here are those held during the cycle that just ended
    always @(posedge clk) begin
        if (freq_tick) n_f++;
        if (data_tick) n_d++;
        if (err_tick)  n_e++;
        if (err_tick && (freq_tick || data_tick)) n_ovl++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input bq_t pkt);
        res_t r;
        logic [7:0] ctrl;
        r = '0;
        if (pkt.size() == PB + 3 && pkt[0] == 8'h0A) begin
            for (int k = 0; k < PB; k++) r.pat = r.pat | (32'(pkt[1+k]) << (8*k));
            r.slow = pkt[PB+1];
            r.fast = pkt[PB+2];
            r.kind = (r.slow != 0 && r.fast != 0) ? 2'd1 : 2'd0;
        end else if (pkt.size() == PB + 2 && pkt[0] == 8'h0B) begin
            for (int k = 0; k < PB; k++) r.pat = r.pat | (32'(pkt[1+k]) << (8*k));
            ctrl   = pkt[PB+1];
            r.ch   = ctrl[7:4];
            r.mode = ctrl[2];
            r.act  = ctrl[1:0];
            r.kind = (int'(r.ch) < OUTPUT_NUM) ? 2'd2 : 2'd0;
        end
        return r;
    endfunction

    task automatic model_reset();
        e_fpat = '0; e_dpat = '0; e_slow = 8'h14; e_fast = 8'h05;
        e_ch = '0; e_mode = 1'b0; e_act = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".fpat"},  freq_pattern, e_fpat);
        chk({tag, ".slow"},  32'(slow_period), 32'(e_slow));
        chk({tag, ".fast"},  32'(fast_period), 32'(e_fast));
        chk({tag, ".dpat"},  data_pattern, e_dpat);
        chk({tag, ".ch"},    32'(channel), 32'(e_ch));
        chk({tag, ".mode"},  32'(mode), 32'(e_mode));
        chk({tag, ".act"},   32'(action), 32'(e_act));
    endtask

    // Called at a negedge; the byte is sampled at the next posedge
    task automatic send_byte(input logic [7:0] b);
        data    = b;
        rx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
        data    = $urandom_range(0, 255);
    endtask

    task automatic run_pkt(input bq_t pkt, input int gap_max, input string tag);
        res_t r;
        r = model(pkt);
        for (int i = 0; i < pkt.size(); i++) begin
            send_byte(pkt[i]);
            if (i == 0 && pkt.size() > 1) chk({tag, ".busy_mid"}, 32'(busy), 32'd1);
            if (i < pkt.size() - 1) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        chk({tag, ".ftick"}, 32'(freq_tick), 32'(r.kind == 2'd1));
        chk({tag, ".dtick"}, 32'(data_tick), 32'(r.kind == 2'd2));
        chk({tag, ".etick"}, 32'(err_tick),  32'(r.kind == 2'd0));
        chk({tag, ".busy_end"}, 32'(busy), 32'd0);
        if (r.kind == 2'd1) begin
            e_fpat = r.pat; e_slow = r.slow; e_fast = r.fast;
        end else if (r.kind == 2'd2) begin
            e_dpat = r.pat; e_ch = r.ch; e_mode = r.mode; e_act = r.act;
        end
        check_outputs(tag);
    endtask

    task automatic mark();
        m_f = n_f; m_d = n_d; m_e = n_e;
    endtask

    task automatic check_counts(input string tag, input int ef, input int ed, input int ee);
        repeat (2) @(negedge clk);
        chk({tag, ".nf"}, 32'(n_f - m_f), 32'(ef));
        chk({tag, ".nd"}, 32'(n_d - m_d), 32'(ed));
        chk({tag, ".ne"}, 32'(n_e - m_e), 32'(ee));
    endtask

    function automatic bq_t rand_pkt(input int kind);
        bq_t q;
        int  v;
        case (kind)
            0, 1: begin
                q.push_back(8'h0A);
                for (int k = 0; k < PB; k++) q.push_back(8'($urandom_range(0, 255)));
                if (kind == 0) begin
                    q.push_back(8'($urandom_range(1, 255)));
                    q.push_back(8'($urandom_range(1, 255)));
                end else if ($urandom_range(0, 1) == 0) begin
                    q.push_back(8'h00);
                    q.push_back(8'($urandom_range(0, 255)));
                end else begin
                    q.push_back(8'($urandom_range(1, 255)));
                    q.push_back(8'h00);
                end
            end
            2, 3: begin
                q.push_back(8'h0B);
                for (int k = 0; k < PB; k++) q.push_back(8'($urandom_range(0, 255)));
                v = (kind == 2) ? $urandom_range(0, OUTPUT_NUM - 1) : $urandom_range(OUTPUT_NUM, 15);
                q.push_back(8'((v << 4) | $urandom_range(0, 15)));
            end
            default: begin
                do v = $urandom_range(0, 255); while (v == 'h0A || v == 'h0B);
                q.push_back(8'(v));
            end
        endcase
        return q;
    endfunction

    initial begin
        bq_t  p;
        res_t r;
        int   k;
        int   waited;
        rst = 1'b1; data = '0; rx_tick = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.ticks", 32'({freq_tick, data_tick, err_tick}), 32'd0);
        check_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        mark();
        p = '{8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h14, 8'h05};
        run_pkt(p, 2, "freq_basic");
        chk("freq_basic.value", freq_pattern, 32'h44332211);
        check_counts("freq_basic", 1, 0, 0);

        mark();
        p = '{8'h0B, 8'h55, 8'h55, 8'h55, 8'h55, 8'h25};
        run_pkt(p, 2, "data_basic");
        chk("data_basic.ch2", 32'(channel), 32'd2);
        chk("data_basic.start", 32'(action), 32'(C_ACTION_START));
        check_counts("data_basic", 0, 1, 0);

        mark();
        p = '{8'h0C};
        run_pkt(p, 0, "unknown");
        p = '{8'h0B, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h07};
        run_pkt(p, 1, "data_ch0");
        check_counts("unknown_then_data", 0, 1, 1);

        mark();
        p = '{8'h0B, 8'h01, 8'h02, 8'h03, 8'h04, 8'h35};
        run_pkt(p, 1, "rej_ch3");
        check_counts("rej_ch3", 0, 0, 1);

        mark();
        p = '{8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h00};
        run_pkt(p, 1, "rej_fast0");
        check_counts("rej_fast0", 0, 0, 1);

        // Back-to-back: the DATA command byte lands on the FREQ commit cycle
        mark();
        p = '{8'h0A, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h33, 8'h02};
        run_pkt(p, 0, "b2b_freq");
        p = '{8'h0B, 8'h0F, 8'hF0, 8'h5A, 8'hA5, 8'h16};
        run_pkt(p, 0, "b2b_data");
        check_counts("b2b", 1, 1, 0);

        // Abort mid-packet with reset
        send_byte(8'h0A); send_byte(8'h99); send_byte(8'h88);
        rst = 1'b1;
        #1;
        model_reset();
        chk("abort.busy", 32'(busy), 32'd0);
        check_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mark();
        p = '{8'h0A, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09, 8'h03};
        run_pkt(p, 1, "after_abort");
        check_counts("after_abort", 1, 0, 0);

        // Randomized packet stream
        for (int it = 0; it < 24; it++) begin
            k = $urandom_range(0, 4);
            p = rand_pkt(k);
            r = model(p);
            mark();
            run_pkt(p, 3, "rand");
            check_counts("rand", int'(r.kind == 2'd1), int'(r.kind == 2'd2), int'(r.kind == 2'd0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef UART_CMD_PARSER_TIMEOUT_EN
        mark();
        send_byte(8'h0A); send_byte(8'h77);
        waited = 0;
        while (!err_tick && waited < TIMEOUT_CLK + 20) begin
            @(negedge clk);
            waited++;
        end
        chk("timeout.latency", 32'(waited), 32'(TIMEOUT_CLK));
        chk("timeout.busy", 32'(busy), 32'd0);
        check_outputs("timeout");
        check_counts("timeout", 0, 0, 1);
        mark();
        p = '{8'h0B, 8'h01, 8'h00, 8'h00, 8'h80, 8'h14};
        run_pkt(p, 1, "after_timeout");
        check_counts("after_timeout", 0, 1, 0);
`else
        waited = 0;
`endif

        chk("tick_overlap", 32'(n_ovl), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Upstream of diff_freq_serial_out.
- Takes the byte stream from the UART receiver (rx_data_o / rx_done_tick_o) and decodes command packets into frequency-table and channel-data register updates.
- Each update is presented atomically with a one-cycle tick.
- diff_freq_serial_out's own byte assembly is replaced by these decoded, validated outputs.

Parameters:
- DATA_BIT, 32, pattern width in bits; must be a multiple of 8. PAT_BYTES = DATA_BIT/8.
- OUTPUT_NUM, 3, number of serial output channels; valid channel indices are 0..OUTPUT_NUM-1.
- CMD_FREQ, 8'h0A, command byte for a frequency update.
- CMD_DATA, 8'h0B, command byte for a data update.
- TIMEOUT_CLK, 8000, maximum clk_i cycles allowed between bytes of one packet (about 2 byte times at 256000 baud, 100 MHz).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- data_i  in  8  received UART byte; valid only when rx_done_tick_i=1
- rx_done_tick_i  in  1  one-cycle strobe, one per byte
- freq_pattern_o  out  DATA_BIT  per-bit fast/slow select pattern
- slow_period_o  out  8  slow bit period in clocks
- fast_period_o  out  8  fast bit period in clocks
- freq_update_tick_o  out  1  one cycle; frequency outputs just updated
- data_pattern_o  out  DATA_BIT  output bit pattern
- channel_o  out  4  target channel
- mode_o  out  1  0 = one-shot, 1 = repeat
- action_o  out  2  control[1:0]; 2'b01 = start
- data_update_tick_o  out  1  one cycle; data outputs just updated
- busy_o  out  1  packet in progress (state != IDLE)
- err_tick_o  out  1  one cycle; packet rejected

Behaviour:
- Reset: all outputs 0. slow_period_o=8'h14, fast_period_o=8'h05. State IDLE; shadow registers 0.
- Bytes are consumed only on cycles with rx_done_tick_i=1.
- Packet formats:
  - FREQ: CMD_FREQ, PAT_BYTES pattern bytes, slow, fast.
  - DATA: CMD_DATA, PAT_BYTES pattern bytes, control.
- Pattern bytes arrive LSB byte first: byte k fills bits [8k+7:8k]. Example: 11 22 33 44 gives 32'h44332211.
- Control byte layout: [7:4] channel, [3] reserved (ignored), [2] mode, [1:0] action.
- FSM states: IDLE, FREQ_PAT, FREQ_SLOW, FREQ_FAST, DATA_PAT, DATA_CTRL.
- Transitions:
  - IDLE: CMD_FREQ goes to FREQ_PAT; CMD_DATA goes to DATA_PAT. Any other byte pulses err_tick_o and stays in IDLE.
  - *_PAT: a byte counter (width $clog2(PAT_BYTES)+1) counts 0..PAT_BYTES-1, then advances the state.
  - FREQ_SLOW goes to FREQ_FAST; FREQ_FAST returns to IDLE; DATA_CTRL returns to IDLE.
- Shadow registers accumulate the packet; public outputs never change mid-packet.
- Commit timing: on the cycle after the final byte's tick, outputs load from shadow and the matching *_update_tick_o pulses. The FSM is already in IDLE on that cycle, so a new command byte arriving then is accepted.
- Validation at the final byte; a rejected packet pulses err_tick_o with no update tick and no output change:
  - slow or fast period == 0: reject.
  - channel >= OUTPUT_NUM: reject.
- A tick is always exactly one cycle. err_tick_o and an update tick never coincide.
- Asserting rst_i mid-packet discards the partial packet; outputs return to reset values.
- busy_o is 1 from the cycle after a valid command byte until the cycle of commit or reject.

Optional Feature:
- Macro: UART_CMD_PARSER_TIMEOUT_EN.
- Defined:
  - A counter ($clog2(TIMEOUT_CLK+1) bits) clears on every rx_done_tick_i and increments while busy_o=1.
  - On reaching TIMEOUT_CLK, the FSM returns to IDLE, err_tick_o pulses once and shadow data is discarded.
- Undefined: no counter is built; the parser waits indefinitely for the next byte.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - state enum
  - CMD_FREQ and CMD_DATA constants
  - control-byte field offsets
  - ACTION_START = 2'b01
  - reset period defaults 8'h14 / 8'h05
- Sub-module cmd_byte_shifter (one per pattern type): a DATA_BIT-wide LSB-first byte accumulator with clear, load-enable and byte index.

Test Plan:
- FREQ packet 0A 11 22 33 44 14 05: freq_pattern_o=32'h44332211, slow=8'h14, fast=8'h05, one freq_update_tick_o; busy_o low afterwards.
- DATA packet 0B 55 55 55 55 25 (channel 2, repeat, start): data_pattern_o=32'h55555555, channel_o=2, mode_o=1, action_o=2'b01, one data_update_tick_o.
- Unknown byte 0C, then a valid DATA packet for channel 0: err_tick_o once for 0C, then a normal update for channel 0.
- Rejects:
  - DATA packet with control 8'h35 (channel 3 with OUTPUT_NUM=3): err_tick_o, no update, outputs unchanged.
  - FREQ packet with fast=8'h00: err_tick_o, no update.
- Reset and abort: rst_i pulsed after 3 bytes of a FREQ packet gives reset values and IDLE, and the following full packet is decoded correctly. With UART_CMD_PARSER_TIMEOUT_EN, stopping after 2 bytes gives err_tick_o TIMEOUT_CLK cycles after the last tick.
- Back-to-back: FREQ then DATA packets with no gap; both ticks occur in order and no byte is lost.
